// File: rtl/sync_rr_arbiter_4ph_if.sv
// Bundle of the upstream 4-phase channels, downstream channel and select/busy status.
// The master modport is the arbiter's view; slave is the requester/resource side.
interface sync_rr_arbiter_4ph_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     req_in;
  logic [N-1:0]     ack_in;
  logic             req_out;
  logic             ack_out;
  logic [IDX_W-1:0] sel;
  logic             busy;

  modport master (
    input  req_in,
    input  ack_out,
    output ack_in,
    output req_out,
    output sel,
    output busy
  );

  modport slave (
    output req_in,
    output ack_out,
    input  ack_in,
    input  req_out,
    input  sel,
    input  busy
  );
endinterface

// File: rtl/sync_rr_arbiter_4ph.sv
// Clocked round-robin arbiter sharing one 4-phase req/ack channel among N 4-phase requesters.
// Inputs pass through SYNC_STAGES flops; every output comes straight from a register.
module sync_rr_arbiter_4ph #(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  sync_rr_arbiter_4ph_if.master bus
);
  localparam int unsigned IDX_W = $clog2(N);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StRel} state_e;

  logic [N-1:0] rq_s;
  logic         ak_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign rq_s = bus.req_in;
    assign ak_s = bus.ack_out;
  end else begin : g_sync
    logic [N-1:0]           rq_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ak_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < SYNC_STAGES; i++) rq_q[i] <= '0;
        ak_q <= '0;
      end else begin
        rq_q[0] <= bus.req_in;
        ak_q[0] <= bus.ack_out;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          rq_q[i] <= rq_q[i-1];
          ak_q[i] <= ak_q[i-1];
        end
      end
    end

    assign rq_s = rq_q[SYNC_STAGES-1];
    assign ak_s = ak_q[SYNC_STAGES-1];
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             req_out_q, req_out_d;
  logic [N-1:0]     ack_in_q, ack_in_d;
  logic             busy_q, busy_d;

  // Rotating priority scan: ptr has highest priority, the port before it the lowest.
  logic             found;
  logic [IDX_W-1:0] winner;
  int unsigned      j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    j      = 0;
    jj     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!found && rq_s[jj]) begin
        found  = 1'b1;
        winner = jj;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    req_out_d = req_out_q;
    ack_in_d  = ack_in_q;
    busy_d    = busy_q;
    unique case (state_q)
      StIdle: begin
        // A resource ack still high from a previous cycle blocks any new grant.
        if (found && !ak_s) begin
          sel_d     = winner;
          req_out_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (ak_s) begin
          ack_in_d        = '0;
          ack_in_d[sel_q] = 1'b1;
          state_d         = StHold;
        end
      end
      StHold: begin
        if (!rq_s[sel_q]) begin
          req_out_d = 1'b0;
          state_d   = StRel;
        end
      end
      StRel: begin
        if (!ak_s) begin
          ack_in_d = '0;
          busy_d   = 1'b0;
          ptr_d    = (sel_q == IDX_W'(N - 1)) ? '0 : sel_q + IDX_W'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      ptr_q     <= '0;
      req_out_q <= 1'b0;
      ack_in_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      req_out_q <= req_out_d;
      ack_in_q  <= ack_in_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req_out = req_out_q;
  assign bus.ack_in  = ack_in_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sync_rr_arbiter_4ph.sv
// Bench for sync_rr_arbiter_4ph: scoreboard of expected grant indices, popped as each
// req_out rises; a second instance without synchronizers checks single-edge handshakes.
module tb_sync_rr_arbiter_4ph;
  localparam int unsigned N       = 4;
  localparam int unsigned S       = 2;
  localparam int          MaxWait = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_rr_arbiter_4ph_if #(.N(N)) a ();
  sync_rr_arbiter_4ph_if #(.N(N)) b ();

  sync_rr_arbiter_4ph #(.N(N), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  sync_rr_arbiter_4ph #(.N(N), .SYNC_STAGES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned sb[$];
  bit          mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic sig(input int code);
    case (code)
      0:       return a.req_out;
      1:       return |a.ack_in;
      2:       return b.req_out;
      3:       return |b.ack_in;
      default: return 1'b0;
    endcase
  endfunction

  // Counts rising edges until the signal reaches val (sampled on falling edges).
  task automatic wait_for(input string tag, input int code, input logic val, output int n);
    n = 0;
    while (sig(code) !== val && n < MaxWait) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " reached"}, 32'(sig(code)), 32'(val));
  endtask

  task automatic do_txn(input bit rerise, input bit last, input bit chk_lat);
    int          n;
    int unsigned exp;
    wait_for("req_out rise", 0, 1'b1, n);
    if (chk_lat) check_eq("lat req_out rise", n, S + 1);
    if (sb.size() == 0) begin
      check_eq("scoreboard empty", 1, 0);
      exp = 0;
    end else begin
      exp = sb.pop_front();
    end
    check_eq("sel at grant", 32'(a.sel), exp);
    check_eq("busy at grant", 32'(a.busy), 1);
    repeat (2) @(negedge clk);
    a.ack_out = 1'b1;
    wait_for("ack_in rise", 1, 1'b1, n);
    if (chk_lat) check_eq("lat ack_in rise", n, S + 1);
    check_eq("ack_in onehot", 32'(a.ack_in), 32'(1) << exp);
    if (last) a.req_in = '0;
    else      a.req_in[exp] = 1'b0;
    wait_for("req_out fall", 0, 1'b0, n);
    if (chk_lat) check_eq("lat req_out fall", n, S + 1);
    a.ack_out = 1'b0;
    wait_for("ack_in fall", 1, 1'b0, n);
    if (chk_lat) check_eq("lat ack_in fall", n, S + 1);
    check_eq("sel stable", 32'(a.sel), exp);
    check_eq("busy cleared", 32'(a.busy), 0);
    if (rerise) a.req_in[exp] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("ack_in at most one", 32'($onehot0(a.ack_in)), 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a.req_in  = '0;
    a.ack_out = 1'b0;
    b.req_in  = '0;
    b.ack_out = 1'b0;

    // Reset with all inputs active, then round robin over all four ports.
    rst       = 1'b1;
    a.req_in  = 4'b1111;
    a.ack_out = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst req_out", 32'(a.req_out), 0);
    check_eq("rst ack_in", 32'(a.ack_in), 0);
    check_eq("rst sel", 32'(a.sel), 0);
    check_eq("rst busy", 32'(a.busy), 0);
    rst       = 1'b0;
    a.ack_out = 1'b0;
    mon_en    = 1'b1;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
    for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b0, 1'b0);
    do_txn(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    // Pointer at 1: port 3 beats port 0.
    a.req_in = 4'b1001;
    sb.push_back(3);
    do_txn(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    // Single requester with full latency checks; pointer then sits at 3.
    a.req_in = 4'b0100;
    sb.push_back(2);
    do_txn(1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // Wrap from pointer 3 to port 0, then port 1.
    a.req_in = 4'b0011;
    sb.push_back(0); sb.push_back(1);
    do_txn(1'b0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    // Resource ack stuck high in IDLE blocks the grant.
    a.ack_out = 1'b1;
    a.req_in  = 4'b0001;
    repeat (10) @(negedge clk);
    check_eq("stuck ack req_out", 32'(a.req_out), 0);
    check_eq("stuck ack busy", 32'(a.busy), 0);
    a.ack_out = 1'b0;
    sb.push_back(0);
    do_txn(1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);

    // Reset while in HOLD aborts the transaction.
    a.req_in = 4'b0010;
    sb.push_back(1);
    wait_for("t6 req_out rise", 0, 1'b1, n);
    check_eq("t6 sel", 32'(a.sel), 32'(sb.pop_front()));
    repeat (2) @(negedge clk);
    a.ack_out = 1'b1;
    wait_for("t6 ack_in rise", 1, 1'b1, n);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6 req_out", 32'(a.req_out), 0);
    check_eq("t6 ack_in", 32'(a.ack_in), 0);
    check_eq("t6 busy", 32'(a.busy), 0);
    check_eq("t6 sel", 32'(a.sel), 0);
    rst       = 1'b0;
    a.req_in  = '0;
    a.ack_out = 1'b0;
    repeat (4) @(negedge clk);

    // No synchronizers: each handshake step takes one edge.
    b.req_in = 4'b0100;
    sb.push_back(2);
    wait_for("s0 req_out rise", 2, 1'b1, n);
    check_eq("s0 lat req_out rise", n, 1);
    check_eq("s0 sel", 32'(b.sel), 32'(sb.pop_front()));
    b.ack_out = 1'b1;
    wait_for("s0 ack_in rise", 3, 1'b1, n);
    check_eq("s0 lat ack_in rise", n, 1);
    check_eq("s0 ack_in", 32'(b.ack_in), 32'h4);
    b.req_in = '0;
    wait_for("s0 req_out fall", 2, 1'b0, n);
    check_eq("s0 lat req_out fall", n, 1);
    b.ack_out = 1'b0;
    wait_for("s0 ack_in fall", 3, 1'b0, n);
    check_eq("s0 lat ack_in fall", n, 1);
    check_eq("s0 busy", 32'(b.busy), 0);

    check_eq("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
